// File: rtl/ebr_burst_reader_if.sv
// Signal bundle between the burst reader, its EBR port and the command/stream side.
// The reader takes the slave view; the environment drives through master.
interface ebr_burst_reader_if #(
    parameter int DATA_WIDTH = 18,
    parameter int ADDR_WIDTH = 9
);
    logic                  CMD_VALID;
    logic                  CMD_READY;
    logic [ADDR_WIDTH-1:0] CMD_ADDR;
    logic [ADDR_WIDTH:0]   CMD_LEN;
    logic                  RAM_CE;
    logic                  RAM_WE;
    logic [ADDR_WIDTH-1:0] RAM_AD;
    logic [DATA_WIDTH-1:0] RAM_DO;
    logic [DATA_WIDTH-1:0] DOUT;
    logic                  DOUT_VALID;
    logic                  DOUT_READY;
    logic                  DOUT_LAST;
    logic                  BUSY;

    modport slave (
        input  CMD_VALID, CMD_ADDR, CMD_LEN, RAM_DO, DOUT_READY,
        output CMD_READY, RAM_CE, RAM_WE, RAM_AD, DOUT, DOUT_VALID, DOUT_LAST, BUSY
    );

    modport master (
        output CMD_VALID, CMD_ADDR, CMD_LEN, RAM_DO, DOUT_READY,
        input  CMD_READY, RAM_CE, RAM_WE, RAM_AD, DOUT, DOUT_VALID, DOUT_LAST, BUSY
    );
endinterface

// File: rtl/ebr_burst_reader.sv
// Burst read sequencer for a single-port EBR: issues back-to-back reads, tracks the
// REGMODE latency with a tag pipe and streams results out through a small credit-guarded FIFO.
module ebr_burst_reader #(
    parameter int    DATA_WIDTH = 18,
    parameter int    ADDR_WIDTH = 9,
    parameter string REGMODE    = "NOREG",
    parameter int    FIFO_DEPTH = 4
) (
    input logic CLK,
    input logic RST,
    ebr_burst_reader_if.slave bus
);
    localparam int LAT = (REGMODE == "OUTREG") ? 2 : 1;
    localparam int CW  = $clog2(FIFO_DEPTH + LAT + 1);
    localparam int PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [ADDR_WIDTH:0]     rem_q, rem_d;
    logic                    busy_q, busy_d;
    logic [ADDR_WIDTH-1:0]   ad_q, ad_d;
    logic [LAT-1:0]          tvld_q, tvld_d;
    logic [LAT-1:0]          tlast_q, tlast_d;
    logic [PW-1:0]           wr_q, wr_d;
    logic [PW-1:0]           rd_q, rd_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [FIFO_DEPTH-1:0][DATA_WIDTH-1:0] mem_q;
    logic [FIFO_DEPTH-1:0]                 lmem_q;

    logic          cmd_ready;
    logic          issue;
    logic          issue_last;
    logic          push;
    logic          pop;
    logic          head_valid;
    logic          head_last;
    logic [CW-1:0] inflight;
    logic [CW-1:0] occ;
    logic          credit_ok;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Credit counts everything already committed to the FIFO: stored words plus reads in flight.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < LAT; i++) begin
            inflight = inflight + CW'(tvld_q[i]);
        end
    end

    assign occ        = cnt_q + inflight;
    assign credit_ok  = occ < CW'(FIFO_DEPTH);
    assign head_valid = (cnt_q != '0);
    assign head_last  = lmem_q[rd_q];
    assign push       = tvld_q[LAT-1];
    assign pop        = head_valid && bus.DOUT_READY;
    assign cmd_ready  = (state_q == IDLE) && !busy_q;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        rem_d      = rem_q;
        busy_d     = busy_q;
        ad_d       = ad_q;
        issue      = 1'b0;
        issue_last = 1'b0;
        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (cmd_ready && bus.CMD_VALID) begin
                    addr_d = bus.CMD_ADDR;
                    rem_d  = bus.CMD_LEN;
                    busy_d = 1'b1;
                    if (bus.CMD_LEN != '0) begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (credit_ok) begin
                    issue      = 1'b1;
                    issue_last = (rem_q == (ADDR_WIDTH+1)'(1));
                    ad_d       = addr_q;
                    addr_d     = addr_q + ADDR_WIDTH'(1);
                    rem_d      = rem_q - (ADDR_WIDTH+1)'(1);
                    if (issue_last) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (pop && head_last) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Tag pipe mirrors the EBR read latency so only issued reads land in the FIFO.
    always_comb begin
        tvld_d     = '0;
        tlast_d    = '0;
        tvld_d[0]  = issue;
        tlast_d[0] = issue_last;
        for (int i = 1; i < LAT; i++) begin
            tvld_d[i]  = tvld_q[i-1];
            tlast_d[i] = tlast_q[i-1];
        end
    end

    always_comb begin
        wr_d  = push ? ptr_inc(wr_q) : wr_q;
        rd_d  = pop  ? ptr_inc(rd_q) : rd_q;
        cnt_d = cnt_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q <= IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            busy_q  <= 1'b0;
            ad_q    <= '0;
            tvld_q  <= '0;
            tlast_q <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            mem_q   <= '0;
            lmem_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            busy_q  <= busy_d;
            ad_q    <= ad_d;
            tvld_q  <= tvld_d;
            tlast_q <= tlast_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
            if (push) begin
                mem_q[wr_q]  <= bus.RAM_DO;
                lmem_q[wr_q] <= tlast_q[LAT-1];
            end
        end
    end

    assign bus.CMD_READY  = cmd_ready;
    assign bus.RAM_CE     = (state_q != IDLE);
    assign bus.RAM_WE     = 1'b0;
    assign bus.RAM_AD     = issue ? addr_q : ad_q;
    assign bus.DOUT       = mem_q[rd_q];
    assign bus.DOUT_VALID = head_valid;
    assign bus.DOUT_LAST  = head_valid && head_last;
    assign bus.BUSY       = busy_q;
endmodule

// File: tb/tb_ebr_burst_reader.sv
// Runs a NOREG and an OUTREG reader side by side on the same commands; a scoreboard
// of expected {last,data} words is built from address arithmetic and checked per instance.
module tb_ebr_burst_reader;
    localparam int DW = 18;
    localparam int AW = 9;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          cmd_valid = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [AW:0]   cmd_len = '0;
    logic          rdy = 1'b1;
    int            rmode = 0;

    logic [1:0]    vld_w, last_w, busy_w, crdy_w, ce_w, we_w;
    logic [DW-1:0] dout_w [2];
    logic [AW-1:0] ad_w [2];

    int errs = 0;
    int checks = 0;
    logic [31:0] exp_q [$];
    int idx [2];
    int nx [2];
    logic          hold_v [2];
    logic [DW-1:0] hold_d [2];
    logic          hold_l [2];
    logic          after_last [2];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_inst
        ebr_burst_reader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
        ebr_burst_reader #(
            .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
            .REGMODE(g == 0 ? "NOREG" : "OUTREG"), .FIFO_DEPTH(4)
        ) dut (.CLK(clk), .RST(rst), .bus(bus));

        logic [DW-1:0] r1, r2;
        // EBR model with mem[i] = i; r2 is the optional output register stage.
        always @(posedge clk) begin
            if (bus.RAM_CE) begin
                r1 <= DW'(bus.RAM_AD);
                r2 <= r1;
            end
        end
        assign bus.RAM_DO     = (g == 0) ? r1 : r2;
        assign bus.CMD_VALID  = cmd_valid;
        assign bus.CMD_ADDR   = cmd_addr;
        assign bus.CMD_LEN    = cmd_len;
        assign bus.DOUT_READY = rdy;
        assign vld_w[g]  = bus.DOUT_VALID;
        assign last_w[g] = bus.DOUT_LAST;
        assign busy_w[g] = bus.BUSY;
        assign crdy_w[g] = bus.CMD_READY;
        assign ce_w[g]   = bus.RAM_CE;
        assign we_w[g]   = bus.RAM_WE;
        assign dout_w[g] = bus.DOUT;
        assign ad_w[g]   = bus.RAM_AD;
    end

    function automatic void chk(input string nm, input int g, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s inst%0d: got %0h expected %0h", nm, g, act, exp);
        end
    endfunction

    // Monitor: pops expected words on each transfer, checks hold-stability and BUSY drop.
    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (!rst) begin
                idx[g] = exp_q.size();
                hold_v[g] = 1'b0;
                after_last[g] = 1'b0;
            end else begin
                if (after_last[g]) begin
                    chk("busy_after_last", g, {30'd0, busy_w[g], crdy_w[g]}, 32'd1);
                    after_last[g] = 1'b0;
                end
                if (hold_v[g] && vld_w[g])
                    chk("stall_stable", g, {13'd0, last_w[g], dout_w[g]}, {13'd0, hold_l[g], hold_d[g]});
                if (vld_w[g] && rdy) begin
                    if (idx[g] >= exp_q.size()) begin
                        chk("unexpected_word", g, {13'd0, last_w[g], dout_w[g]}, 32'hFFFF_FFFF);
                    end else begin
                        chk("data", g, {13'd0, last_w[g], dout_w[g]}, exp_q[idx[g]]);
                        idx[g]++;
                    end
                    nx[g]++;
                    if (last_w[g]) begin
                        chk("busy_at_last", g, {31'd0, busy_w[g]}, 32'd1);
                        after_last[g] = 1'b1;
                    end
                end
                hold_v[g] = vld_w[g] && !rdy;
                hold_d[g] = dout_w[g];
                hold_l[g] = last_w[g];
            end
        end
    end

    initial begin : ready_drv
        int pc;
        pc = 0;
        forever begin
            @(posedge clk);
            #1;
            case (rmode)
                1:       rdy = (pc % 4 == 0) || (pc % 4 == 3);
                2:       rdy = ($urandom_range(0, 3) != 0);
                default: rdy = 1'b1;
            endcase
            pc++;
        end
    end

    task automatic check_reset();
        for (int g = 0; g < 2; g++) begin
            chk("rst_cmd_ready", g, {31'd0, crdy_w[g]}, 32'd1);
            chk("rst_ram_ce", g, {31'd0, ce_w[g]}, 32'd0);
            chk("rst_ram_we", g, {31'd0, we_w[g]}, 32'd0);
            chk("rst_ram_ad", g, {23'd0, ad_w[g]}, 32'd0);
            chk("rst_dout", g, {14'd0, dout_w[g]}, 32'd0);
            chk("rst_dout_valid", g, {31'd0, vld_w[g]}, 32'd0);
            chk("rst_dout_last", g, {31'd0, last_w[g]}, 32'd0);
            chk("rst_busy", g, {31'd0, busy_w[g]}, 32'd0);
        end
    endtask

    // Called just after a posedge with both readers idle; returns just after the accept edge.
    task automatic send(input int a, input int len);
        for (int i = 0; i < len; i++)
            exp_q.push_back({13'd0, (i == len - 1), 9'd0, 9'((a + i) % 512)});
        cmd_addr  = AW'(a);
        cmd_len   = (AW+1)'(len);
        cmd_valid = 1'b1;
        @(negedge clk);
        chk("cmd_ready_at_send", 0, {30'd0, crdy_w}, 32'd3);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(busy_w == 2'b00 && crdy_w == 2'b11) && n < 6000);
        if (n >= 6000) chk(nm, 0, {30'd0, busy_w}, 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin : driver
        int lat [2];
        int vcnt [2];
        int vend [2];
        int bcnt [2];
        int base;
        int n;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Basic burst: latency L+2 and back-to-back words.
        rmode = 0;
        send(16, 4);
        for (int g = 0; g < 2; g++) begin lat[g] = 0; vcnt[g] = 0; vend[g] = 0; end
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            for (int g = 0; g < 2; g++) begin
                if (vld_w[g]) begin
                    if (lat[g] == 0) lat[g] = c;
                    vcnt[g]++;
                    vend[g] = c;
                end
            end
        end
        chk("first_latency", 0, lat[0], 3);
        chk("first_latency", 1, lat[1], 4);
        for (int g = 0; g < 2; g++) begin
            chk("valid_cycles", g, vcnt[g], 4);
            chk("no_gaps", g, vend[g] - lat[g], 3);
        end
        wait_idle("idle_basic");

        send(510, 4);
        wait_idle("idle_wrap");

        rmode = 1;
        send(32, 16);
        wait_idle("idle_backpressure");

        rmode = 0;
        send(5, 0);
        bcnt[0] = 0; bcnt[1] = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            for (int g = 0; g < 2; g++) if (busy_w[g]) bcnt[g]++;
        end
        chk("len0_busy_cycles", 0, bcnt[0], 1);
        chk("len0_busy_cycles", 1, bcnt[1], 1);
        @(posedge clk);
        #1;

        rmode = 2;
        send(256, 512);
        wait_idle("idle_full");

        for (int k = 0; k < 6; k++) begin
            send($urandom_range(0, 511), $urandom_range(1, 40));
            wait_idle("idle_random");
        end

        // Reset after the third word of the NOREG reader.
        rmode = 0;
        base = nx[0];
        send(64, 8);
        n = 0;
        while (nx[0] < base + 3 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("third_word_seen", 0, nx[0] - base, 3);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        send(200, 2);
        wait_idle("idle_after_reset");
        repeat (4) @(posedge clk);

        chk("all_words_seen", 0, idx[0], exp_q.size());
        chk("all_words_seen", 1, idx[1], exp_q.size());
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
